// File: rtl/alu_sequencer.sv
// Command-level controller for the accumulator ALU: sequences one command at a time into
// registered ALU controls, builds MUL from repeated ADDs, and returns the accumulator value.
module alu_sequencer (
  input  logic       Clk,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy,
  output logic [7:0] BusOut,
  output logic       Wen,
  output logic       INC,
  output logic       ac_rst,
  output logic [2:0] alu_op,
  input  logic [7:0] dout
);

  localparam int unsigned DW = 8;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_MUL_CLR = 3'd2,
    S_MUL_ADD = 3'd3,
    S_CAPTURE = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_busy;
  logic          r_res_valid;
  logic [DW-1:0] r_res_data;
  logic [DW-1:0] r_bus;
  logic          r_wen;
  logic          r_inc;
  logic          r_ac_rst;
  logic [2:0]    r_alu_op;
  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_cnt;

  // Controls are registered on the edge entering the state that owns them, so each
  // state's ALU action is visible for exactly the cycle the state is resident.
  always_ff @(posedge Clk) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_bus       <= '0;
      r_wen       <= 1'b0;
      r_inc       <= 1'b0;
      r_ac_rst    <= 1'b1;
      r_alu_op    <= ALU_NONE;
      r_mcand     <= '0;
      r_cnt       <= '0;
    end else begin
      r_bus    <= '0;
      r_wen    <= 1'b0;
      r_inc    <= 1'b0;
      r_ac_rst <= 1'b0;
      r_alu_op <= ALU_NONE;

      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_op == OP_MUL) begin
              r_mcand  <= dout;
              r_cnt    <= cmd_data;
              r_ac_rst <= 1'b1;
              r_state  <= S_MUL_CLR;
            end else begin
              r_state <= S_ISSUE;
              case (cmd_op)
                OP_LOAD: begin r_wen <= 1'b1;      r_bus <= cmd_data; end
                OP_ADD:  begin r_alu_op <= ALU_ADD; r_bus <= cmd_data; end
                OP_SUB:  begin r_alu_op <= ALU_SUB; r_bus <= cmd_data; end
                OP_AND:  begin r_alu_op <= ALU_AND; r_bus <= cmd_data; end
                OP_OR:   begin r_alu_op <= ALU_OR;  r_bus <= cmd_data; end
                OP_CLR:  r_ac_rst <= 1'b1;
                OP_INC:  r_inc <= 1'b1;
                default: ;
              endcase
            end
          end
        end

        S_ISSUE: r_state <= S_CAPTURE;

        S_MUL_CLR: begin
          r_state <= S_MUL_ADD;
          if (r_cnt != '0) begin
            r_alu_op <= ALU_ADD;
            r_bus    <= r_mcand;
          end
        end

        // An ADD cycle is scheduled only while the count about to be tested is non-zero.
        S_MUL_ADD: begin
          if (r_cnt == '0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - DW'(1);
            if (r_cnt != DW'(1)) begin
              r_alu_op <= ALU_ADD;
              r_bus    <= r_mcand;
            end
          end
        end

        S_CAPTURE: begin
          r_res_data  <= dout;
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign BusOut    = r_bus;
  assign Wen       = r_wen;
  assign INC       = r_inc;
  assign ac_rst    = r_ac_rst;
  assign alu_op    = r_alu_op;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: accumulator ALU model on the control bus, command-level
// reference model for results, latencies and control-cycle counts.
module tb_alu_sequencer;

  logic       Clk;
  logic       RST;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic [7:0] BusOut;
  logic       Wen;
  logic       INC;
  logic       ac_rst;
  logic [2:0] alu_op;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] acc_m;
  logic [7:0] ac;

  alu_sequencer dut (
    .Clk(Clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .BusOut(BusOut), .Wen(Wen), .INC(INC), .ac_rst(ac_rst),
    .alu_op(alu_op), .dout(dout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Accumulator ALU: RST > Wen > INC > alu_op, mod-256 arithmetic.
  always @(posedge Clk) begin
    if (ac_rst)   ac <= 8'd0;
    else if (Wen) ac <= BusOut;
    else if (INC) ac <= ac + 8'd1;
    else begin
      case (alu_op)
        3'd1:    ac <= ac + BusOut;
        3'd2:    ac <= ac - BusOut;
        3'd3:    ac <= ac & BusOut;
        3'd4:    ac <= ac | BusOut;
        default: ac <= ac;
      endcase
    end
  end
  assign dout = ac;

  function automatic logic [7:0] ref_apply(input logic [2:0] op, input logic [7:0] d,
                                           input logic [7:0] a);
    int unsigned p;
    p = 0;
    case (op)
      3'd0: p = d;
      3'd1: p = int'(a) + int'(d);
      3'd2: p = int'(a) + 256 - int'(d);
      3'd3: p = int'(a & d);
      3'd4: p = int'(a | d);
      3'd5: p = 0;
      3'd6: p = int'(a) + 1;
      default: p = int'(a) * int'(d);
    endcase
    return 8'(p % 256);
  endfunction

  // Issues one command and watches it until res_valid; leaves the result un-consumed.
  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] bus_exp,
                      output int lat, output logic [7:0] res, output int n_rst,
                      output int n_add, output int n_ctrl, output int n_bus,
                      output bit rdy_seen, output bit tmo);
    int w;
    lat = 0; res = 8'd0; n_rst = 0; n_add = 0; n_ctrl = 0; n_bus = 0;
    rdy_seen = 1'b0; tmo = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge Clk); #1; w++;
    end
    if (!cmd_ready) begin
      tmo = 1'b1;
      return;
    end
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_data = 8'($urandom);
    while (!res_valid && lat < 300) begin
      if (cmd_ready) rdy_seen = 1'b1;
      if (ac_rst) n_rst++;
      if (alu_op == 3'd1) n_add++;
      if (Wen || INC || ac_rst || alu_op != 3'd0) n_ctrl++;
      if ((Wen || alu_op != 3'd0) && BusOut == bus_exp) n_bus++;
      @(posedge Clk); #1;
      lat++;
    end
    if (!res_valid) tmo = 1'b1;
    res = res_data;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %0b exp 0", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %0b exp 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (res_data !== 8'd0) begin errors++; $display("FAIL rst_res_data got %0d exp 0", res_data); end
    checks++; if ({Wen, INC, alu_op, BusOut} !== 13'd0) begin errors++; $display("FAIL rst_ctrl got %0h exp 0", {Wen, INC, alu_op, BusOut}); end
    checks++; if (ac_rst !== 1'b1) begin errors++; $display("FAIL rst_ac_rst got %0b exp 1", ac_rst); end
    RST = 1'b0;
    @(posedge Clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready got %0b exp 1", cmd_ready); end
    checks++; if (ac_rst !== 1'b0) begin errors++; $display("FAIL post_rst_ac_rst got %0b exp 0", ac_rst); end
    checks++; if (dout !== 8'd0) begin errors++; $display("FAIL post_rst_alu_clear got %0d exp 0", dout); end
    acc_m = 8'd0;
  endtask

  task automatic test_load_first();
    cmd_op = 3'd0; cmd_data = 8'd35; cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
    checks++; if ({Wen, BusOut} !== {1'b1, 8'd35}) begin errors++; $display("FAIL load_ctrl got Wen=%0b BusOut=%0d exp Wen=1 BusOut=35", Wen, BusOut); end
    checks++; if ({cmd_ready, res_valid, busy} !== 3'b001) begin errors++; $display("FAIL load_e1_flags got %03b exp 001", {cmd_ready, res_valid, busy}); end
    @(posedge Clk); #1;
    checks++; if ({res_valid, cmd_ready, Wen} !== 3'b000) begin errors++; $display("FAIL load_e2_flags got %03b exp 000", {res_valid, cmd_ready, Wen}); end
    @(posedge Clk); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL load_res_valid got %0b exp 1", res_valid); end
    checks++; if (res_data !== 8'd35) begin errors++; $display("FAIL load_res_data got %0d exp 35", res_data); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_resp_cmd_ready got %0b exp 0", cmd_ready); end
    consume();
    checks++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin errors++; $display("FAIL load_done_flags got %03b exp 010", {res_valid, cmd_ready, busy}); end
    acc_m = 8'd35;
  endtask

  task automatic test_alu_ops();
    logic [2:0] ops [4];
    logic [7:0] dat [4];
    logic [7:0] exp_tab [4];
    int lat, n_rst, n_add, n_ctrl, n_bus;
    logic [7:0] res;
    bit rdy, tmo;
    ops = '{3'd0, 3'd1, 3'd2, 3'd3};
    dat = '{8'd35, 8'd10, 8'd3, 8'h0F};
    exp_tab = '{8'd35, 8'd45, 8'd42, 8'd10};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], dat[i], dat[i], lat, res, n_rst, n_add, n_ctrl, n_bus, rdy, tmo);
      checks++; if (res !== exp_tab[i]) begin errors++; $display("FAIL ops_res[%0d] got %0d exp %0d", i, res, exp_tab[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL ops_lat[%0d] got %0d exp 2", i, lat); end
      checks++; if (n_bus !== 1) begin errors++; $display("FAIL ops_bus[%0d] got %0d exp 1", i, n_bus); end
      consume();
    end
    acc_m = 8'd10;
  endtask

  task automatic test_mul();
    logic [7:0] a_tab [3];
    logic [7:0] n_tab [3];
    logic [7:0] e_tab [3];
    int lat, n_rst, n_add, n_ctrl, n_bus;
    logic [7:0] res;
    bit rdy, tmo;
    a_tab = '{8'd12, 8'd200, 8'd7};
    n_tab = '{8'd3, 8'd2, 8'd0};
    e_tab = '{8'd36, 8'd144, 8'd0};
    for (int i = 0; i < 3; i++) begin
      send(3'd0, a_tab[i], a_tab[i], lat, res, n_rst, n_add, n_ctrl, n_bus, rdy, tmo);
      checks++; if (res !== a_tab[i]) begin errors++; $display("FAIL mul_load[%0d] got %0d exp %0d", i, res, a_tab[i]); end
      consume();
      send(3'd7, n_tab[i], a_tab[i], lat, res, n_rst, n_add, n_ctrl, n_bus, rdy, tmo);
      checks++; if (res !== e_tab[i]) begin errors++; $display("FAIL mul_res[%0d] got %0d exp %0d", i, res, e_tab[i]); end
      checks++; if (lat !== int'(n_tab[i]) + 3) begin errors++; $display("FAIL mul_lat[%0d] got %0d exp %0d", i, lat, int'(n_tab[i]) + 3); end
      checks++; if (n_rst !== 1) begin errors++; $display("FAIL mul_clr[%0d] got %0d exp 1", i, n_rst); end
      checks++; if ({n_add, n_bus} !== {int'(n_tab[i]), int'(n_tab[i])}) begin errors++; $display("FAIL mul_adds[%0d] got adds=%0d bus=%0d exp %0d", i, n_add, n_bus, n_tab[i]); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mul_cmd_ready[%0d] got %0b exp 0", i, rdy); end
      consume();
    end
    acc_m = 8'd0;
  endtask

  task automatic test_backpressure();
    int lat, n_rst, n_add, n_ctrl, n_bus;
    logic [7:0] res, e;
    bit rdy, tmo;
    e = ref_apply(3'd6, 8'd0, acc_m);
    send(3'd6, 8'd0, 8'd0, lat, res, n_rst, n_add, n_ctrl, n_bus, rdy, tmo);
    checks++; if (res !== e) begin errors++; $display("FAIL bp_res got %0d exp %0d", res, e); end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      checks++; if ({res_valid, res_data, cmd_ready} !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL bp_hold[%0d] got valid=%0b data=%0d ready=%0b exp 1 %0d 0", i, res_valid, res_data, cmd_ready, e); end
      checks++; if ({Wen, INC, ac_rst, alu_op, BusOut} !== 14'd0) begin errors++; $display("FAIL bp_ctrl[%0d] got %0h exp 0", i, {Wen, INC, ac_rst, alu_op, BusOut}); end
    end
    consume();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", cmd_ready); end
    acc_m = e;
  endtask

  task automatic test_reset_mid();
    int lat, n_rst, n_add, n_ctrl, n_bus;
    logic [7:0] res;
    bit rdy, tmo;
    cmd_op = 3'd7; cmd_data = 8'd50; cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    RST = 1'b1;
    @(posedge Clk); #1;
    checks++; if (ac_rst !== 1'b1) begin errors++; $display("FAIL mid_ac_rst got %0b exp 1", ac_rst); end
    checks++; if ({res_valid, cmd_ready, busy} !== 3'b000) begin errors++; $display("FAIL mid_flags got %03b exp 000", {res_valid, cmd_ready, busy}); end
    checks++; if ({Wen, INC, alu_op, BusOut} !== 13'd0) begin errors++; $display("FAIL mid_ctrl got %0h exp 0", {Wen, INC, alu_op, BusOut}); end
    RST = 1'b0;
    @(posedge Clk); #1;
    checks++; if ({cmd_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL mid_idle got %02b exp 10", {cmd_ready, res_valid}); end
    acc_m = 8'd0;
    send(3'd0, 8'd9, 8'd9, lat, res, n_rst, n_add, n_ctrl, n_bus, rdy, tmo);
    checks++; if (res !== 8'd9) begin errors++; $display("FAIL mid_load9 got %0d exp 9", res); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mid_load9_lat got %0d exp 2", lat); end
    consume();
    acc_m = 8'd9;
  endtask

  task automatic test_random();
    int lat, n_rst, n_add, n_ctrl, n_bus, exp_lat, exp_ctrl, exp_bus;
    logic [7:0] res, e, d, bx;
    logic [2:0] op;
    bit rdy, tmo;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (op == 3'd7 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 9));
      e = ref_apply(op, d, acc_m);
      bx = (op == 3'd7) ? acc_m : d;
      exp_lat = (op == 3'd7) ? int'(d) + 3 : 2;
      exp_ctrl = (op == 3'd7) ? int'(d) + 1 : 1;
      exp_bus = (op == 3'd7) ? int'(d) : ((op <= 3'd4) ? 1 : 0);
      send(op, d, bx, lat, res, n_rst, n_add, n_ctrl, n_bus, rdy, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rnd_timeout[%0d] op=%0d got %0b exp 0", i, op, tmo); end
      checks++; if (res !== e) begin errors++; $display("FAIL rnd_res[%0d] op=%0d d=%0d got %0d exp %0d", i, op, d, res, e); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d] op=%0d got %0d exp %0d", i, op, lat, exp_lat); end
      checks++; if ({n_ctrl, n_bus} !== {exp_ctrl, exp_bus}) begin errors++; $display("FAIL rnd_ctrl[%0d] op=%0d got ctrl=%0d bus=%0d exp %0d %0d", i, op, n_ctrl, n_bus, exp_ctrl, exp_bus); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rnd_cmd_ready[%0d] got %0b exp 0", i, rdy); end
      repeat ($urandom_range(0, 3)) begin
        @(posedge Clk); #1;
        checks++; if ({res_valid, res_data} !== {1'b1, e}) begin errors++; $display("FAIL rnd_hold[%0d] got %0b %0d exp 1 %0d", i, res_valid, res_data, e); end
      end
      consume();
      acc_m = e;
    end
  endtask

  initial begin
    test_reset();
    test_load_first();
    test_alu_ops();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the accumulator ALU. Accepts one command at a time over a valid/ready port and drives the ALU control inputs (BusOut, Wen, INC, RST, alu_op) for each command. It samples the ALU's dout and returns the accumulator value over a valid/ready result port. MUL is built from repeated ADDs, so multiply needs no extra datapath in the ALU.

## Interface
- No parameters; data width fixed at 8 bits.
- Clk  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset of this block.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  3  000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 CLR, 110 INC, 111 MUL.
- cmd_data  in  8  operand; for MUL, the multiplier n.
- res_valid  out  1  res_data holds the post-command accumulator value.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  captured accumulator value.
- busy  out  1  high in every state except IDLE.
- BusOut  out  8  ALU operand bus.
- Wen  out  1  ALU load: AC <= BusOut.
- INC  out  1  ALU increment: AC <= AC+1.
- ac_rst  out  1  ALU clear; drives the ALU RST input.
- alu_op  out  3  ALU op: 000 none, 001 ADD, 010 SUB, 011 AND, 100 OR.
- dout  in  8  ALU accumulator value.

## Operation
- ALU contract: AC updates one edge after the controls are driven. Priority is RST > Wen > INC > alu_op. Arithmetic is mod 256. dout reflects AC.
- States: IDLE, ISSUE, MUL_CLR, MUL_ADD, CAPTURE, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch op and data. Go to MUL_CLR if op=MUL, else ISSUE.
- ISSUE: drive exactly one ALU control for one cycle.
  - LOAD: Wen=1, BusOut=data.
  - ADD/SUB/AND/OR: alu_op=001/010/011/100, BusOut=data.
  - CLR: ac_rst=1.
  - INC: INC=1.
  - Then go to CAPTURE.
- MUL_CLR: on entry, mcand <= dout (the accumulator value before the command) and cnt <= data. Drive ac_rst=1 for one cycle, then go to MUL_ADD.
- MUL_ADD: if cnt=0, go to CAPTURE with no ALU control. Otherwise drive alu_op=001 with BusOut=mcand and decrement cnt.
- CAPTURE: no ALU control. res_data <= dout. Go to RESP.
- RESP: res_valid=1. Stay until res_ready=1, then go to IDLE.
- Outside the states listed above, all ALU controls are 0 and BusOut is 0.
- Operand capture: cmd_op and cmd_data are ignored except at the accept edge; the latched copies are used for the whole command.
- MUL result is (AC_old × n) mod 256. n=0 gives 0.

## Timing
- Reset: cmd_ready=0 while RST is high and 1 in the first cycle after.
  - res_valid=0, busy=0, res_data=0.
  - BusOut=0, Wen=0, INC=0, alu_op=000.
  - ac_rst=1 while RST is high, so the ALU clears with the block.
- Accept edge E0 is the edge where cmd_valid & cmd_ready.
- Non-MUL commands: ALU controls active in the cycle after E0. res_valid rises 2 edges after E0.
- MUL n: ac_rst active the cycle after E0, then n ADD cycles, one cnt=0 cycle, and CAPTURE. res_valid rises n+3 edges after E0.
- A result is consumed on the edge where res_valid & res_ready. cmd_ready rises in the next cycle; there is no same-cycle turnaround.
- Back-pressure: res_data and res_valid stay stable while res_ready=0.
- Reset mid-command: the block aborts on the next edge and returns to IDLE. Any pending result is discarded.

## Test plan
- Reset, then LOAD 35 at E0 → Wen=1 and BusOut=35 in the next cycle; res_valid=1 with res_data=35 at E0+2; cmd_ready=0 throughout.
- LOAD 35, ADD 10, SUB 3, AND 0x0F → results 35, 45, 42, 10, each at accept edge +2.
- LOAD 12, then MUL 3 → ac_rst pulses once, then 3 ADD cycles with BusOut=12; res_data=36 at E0+6.
- LOAD 200, then MUL 2 → res_data=144 (wrap). LOAD 7, then MUL 0 → res_data=0 at E0+3.
- Hold res_ready=0 for 5 cycles after INC → res_valid and res_data stay stable; cmd_ready stays 0; the ALU sees no controls.
- RST pulsed during MUL 50 → IDLE on the next edge; ac_rst=1 during reset; res_valid=0; a following LOAD 9 returns 9.
